// File: rtl/bus_xfer_seq_if.sv
// ---------------------------------------------------------------------------
// bus_xfer_seq_if
// Groups the request side and the register-bank side of the bus transfer
// sequencer into one bundle.
//   req, clr_op, src, dst : transfer request from the control decoder
//   bus_in                : 12-bit shared data bus as seen by the sequencer
//   oe                    : one-hot source output enables (NSRC wide)
//   latch, clear          : one-hot destination strobes (NDST wide)
//   bus_cap               : bus value captured at strobe start
//   busy, done, err       : sequencer status
// The master modport is the sequencer's view; slave is the surrounding logic.
// ---------------------------------------------------------------------------
interface bus_xfer_seq_if #(
   parameter int NSRC = 8,
   parameter int NDST = 8
);
   logic            req;
   logic            clr_op;
   logic [2:0]      src;
   logic [2:0]      dst;
   logic [11:0]     bus_in;
   logic [NSRC-1:0] oe;
   logic [NDST-1:0] latch;
   logic [NDST-1:0] clear;
   logic [11:0]     bus_cap;
   logic            busy;
   logic            done;
   logic            err;

   modport master (
      input  req, clr_op, src, dst, bus_in,
      output oe, latch, clear, bus_cap, busy, done, err
   );

   modport slave (
      output req, clr_op, src, dst, bus_in,
      input  oe, latch, clear, bus_cap, busy, done, err
   );
endinterface

// File: rtl/bus_xfer_seq.sv
// ---------------------------------------------------------------------------
// bus_xfer_seq
// Initiator side of the 12-bit shared register bus. Runs one register-to-
// register transfer at a time: enable the source, let the bus settle, strobe
// the destination latch, hold the source one more cycle, then release. A
// clear-only request strobes the destination's clear line instead.
// Ports:
//   CLK      : system clock, all state changes on the rising edge
//   reset_n  : synchronous active-low reset
//   bus      : bus_xfer_seq_if.master (request inputs, bus_in, strobes, status)
// Parameters:
//   NSRC, NDST : number of sources / destinations
//   SETTLE     : cycles oe is held before the latch strobe (>=1)
//   STROBE     : cycles latch/clear is held high (>=1)
// ---------------------------------------------------------------------------
module bus_xfer_seq #(
   parameter int NSRC   = 8,
   parameter int NDST   = 8,
   parameter int SETTLE = 1,
   parameter int STROBE = 1
) (
   input logic CLK,
   input logic reset_n,
   bus_xfer_seq_if.master bus
);

   // Counter holds values up to max(SETTLE,STROBE)-1 and is never narrower
   // than two bits.
   localparam int MAXC = (SETTLE > STROBE) ? SETTLE : STROBE;
   localparam int CW   = ($clog2(MAXC) < 2) ? 2 : $clog2(MAXC);
   localparam logic [CW-1:0] SETTLE_LD = CW'(SETTLE - 1);
   localparam logic [CW-1:0] STROBE_LD = CW'(STROBE - 1);

   typedef enum logic [2:0] {
      IDLE,
      DRIVE,
      STRB,
      REL,
      CLR,
      FIN
   } state_t;

   state_t          state;
   logic [CW-1:0]   cnt;
   logic [2:0]      dst_q;
   logic [NSRC-1:0] oe_q;
   logic [NDST-1:0] latch_q;
   logic [NDST-1:0] clear_q;
   logic [11:0]     cap_q;
   logic            done_q;
   logic            err_q;

   logic            src_bad;
   logic            dst_bad;
   logic [NSRC-1:0] src_hot;
   logic [NDST-1:0] dst_hot_in;
   logic [NDST-1:0] dst_hot_q;

   // Range checks and one-hot decodes. The decodes are only used once the
   // index has passed its range check, so an out-of-range shift never
   // reaches a strobe.
   assign src_bad    = (int'(bus.src) >= NSRC);
   assign dst_bad    = (int'(bus.dst) >= NDST);
   assign src_hot    = NSRC'(1) << bus.src;
   assign dst_hot_in = NDST'(1) << bus.dst;
   assign dst_hot_q  = NDST'(1) << dst_q;

   // Sequencer. Every strobe is a register so the bank sees glitch-free
   // enables. The destination index is captured at accept because the
   // latch strobe fires several cycles later, after the requester may have
   // moved on.
   always_ff @(posedge CLK) begin
      if (!reset_n) begin
         state   <= IDLE;
         cnt     <= '0;
         dst_q   <= '0;
         oe_q    <= '0;
         latch_q <= '0;
         clear_q <= '0;
         cap_q   <= '0;
         done_q  <= 1'b0;
         err_q   <= 1'b0;
      end else begin
         done_q <= 1'b0;
         err_q  <= 1'b0;
         case (state)
            IDLE: begin
               if (bus.req) begin
                  dst_q <= bus.dst;
                  if (bus.clr_op) begin
                     if (dst_bad) begin
                        state  <= FIN;
                        done_q <= 1'b1;
                        err_q  <= 1'b1;
                     end else begin
                        state   <= CLR;
                        clear_q <= dst_hot_in;
                        cnt     <= STROBE_LD;
                     end
                  end else if (src_bad || dst_bad) begin
                     state  <= FIN;
                     done_q <= 1'b1;
                     err_q  <= 1'b1;
                  end else begin
                     state <= DRIVE;
                     oe_q  <= src_hot;
                     cnt   <= SETTLE_LD;
                  end
               end
            end
            DRIVE: begin
               if (cnt == '0) begin
                  state   <= STRB;
                  latch_q <= dst_hot_q;
                  cap_q   <= bus.bus_in;
                  cnt     <= STROBE_LD;
               end else begin
                  cnt <= cnt - 1'b1;
               end
            end
            // The source stays enabled for one cycle after the latch drops
            // so the destination sees stable data through its hold window.
            STRB: begin
               if (cnt == '0) begin
                  state   <= REL;
                  latch_q <= '0;
               end else begin
                  cnt <= cnt - 1'b1;
               end
            end
            REL: begin
               state  <= FIN;
               oe_q   <= '0;
               done_q <= 1'b1;
            end
            CLR: begin
               if (cnt == '0) begin
                  state   <= FIN;
                  clear_q <= '0;
                  done_q  <= 1'b1;
               end else begin
                  cnt <= cnt - 1'b1;
               end
            end
            FIN: begin
               state <= IDLE;
            end
            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

   assign bus.oe      = oe_q;
   assign bus.latch   = latch_q;
   assign bus.clear   = clear_q;
   assign bus.bus_cap = cap_q;
   assign bus.busy    = (state != IDLE);
   assign bus.done    = done_q;
   assign bus.err     = err_q;

endmodule

// File: tb/tb_bus_xfer_seq.sv
// ---------------------------------------------------------------------------
// tb_bus_xfer_seq
// Directed bench for bus_xfer_seq. Instance A uses SETTLE=1/STROBE=1 with
// eight sources and destinations; instance B uses SETTLE=3/STROBE=2 with six
// of each so that a 3-bit index can fall out of range.
// ---------------------------------------------------------------------------
module tb_bus_xfer_seq;

   logic CLK;
   logic reset_n;
   int   checks;
   int   failures;
   bit   monOn;

   bus_xfer_seq_if #(.NSRC(8), .NDST(8)) busA ();
   bus_xfer_seq_if #(.NSRC(6), .NDST(6)) busB ();

   bus_xfer_seq #(.NSRC(8), .NDST(8), .SETTLE(1), .STROBE(1)) dutA (
      .CLK     (CLK),
      .reset_n (reset_n),
      .bus     (busA)
   );

   bus_xfer_seq #(.NSRC(6), .NDST(6), .SETTLE(3), .STROBE(2)) dutB (
      .CLK     (CLK),
      .reset_n (reset_n),
      .bus     (busB)
   );

   // Free-running 10-unit clock.
   initial CLK = 1'b0;
   always #5 CLK = ~CLK;

   // One comparison: count it, and on a miss count and report it.
   task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   // Drive the request inputs of one instance (0 = A, 1 = B).
   task automatic applyStimulus(input int which, input logic req, input logic clrOp,
                                input logic [2:0] src, input logic [2:0] dst,
                                input logic [11:0] busIn);
      if (which == 0) begin
         busA.req    = req;
         busA.clr_op = clrOp;
         busA.src    = src;
         busA.dst    = dst;
         busA.bus_in = busIn;
      end else begin
         busB.req    = req;
         busB.clr_op = clrOp;
         busB.src    = src;
         busB.dst    = dst;
         busB.bus_in = busIn;
      end
   endtask

   // Advance one rising edge and settle just past it.
   task automatic stepClock();
      @(posedge CLK);
      #1;
   endtask

   // Structural invariants sampled on every falling edge for both instances.
   always @(negedge CLK) begin
      if (monOn) begin
         checkOutput("onehotA", 32'($onehot0(busA.oe)), 32'd1);
         checkOutput("onehotB", 32'($onehot0(busB.oe)), 32'd1);
         checkOutput("latchNeedsOeA", 32'((busA.latch == '0) || (busA.oe != '0)), 32'd1);
         checkOutput("latchNeedsOeB", 32'((busB.latch == '0) || (busB.oe != '0)), 32'd1);
         checkOutput("latchClearExclA", 32'((busA.latch & busA.clear) == '0), 32'd1);
         checkOutput("latchClearExclB", 32'((busB.latch & busB.clear) == '0), 32'd1);
      end
   end

   initial begin
      int ph;
      logic [7:0] oeExp;
      checks   = 0;
      failures = 0;
      monOn    = 1'b0;
      reset_n  = 1'b0;
      applyStimulus(0, 1'b0, 1'b0, 3'd0, 3'd0, 12'h000);
      applyStimulus(1, 1'b0, 1'b0, 3'd0, 3'd0, 12'h000);

      // Reset state.
      stepClock();
      stepClock();
      checkOutput("rstOe",     32'(busA.oe),      32'h0);
      checkOutput("rstLatch",  32'(busA.latch),   32'h0);
      checkOutput("rstClear",  32'(busA.clear),   32'h0);
      checkOutput("rstBusCap", 32'(busA.bus_cap), 32'h0);
      checkOutput("rstBusy",   32'(busA.busy),    32'h0);
      checkOutput("rstDone",   32'(busA.done),    32'h0);
      checkOutput("rstErr",    32'(busA.err),     32'h0);
      checkOutput("rstBusyB",  32'(busB.busy),    32'h0);
      monOn   = 1'b1;
      reset_n = 1'b1;
      stepClock();

      // Transfer src=2 -> dst=5 on A.
      $display("[TB] transfer src=2 dst=5");
      applyStimulus(0, 1'b1, 1'b0, 3'd2, 3'd5, 12'o5252);
      stepClock();
      applyStimulus(0, 1'b0, 1'b0, 3'd7, 3'd1, 12'o5252);
      checkOutput("t1c1Oe",    32'(busA.oe),    32'h04);
      checkOutput("t1c1Latch", 32'(busA.latch), 32'h00);
      checkOutput("t1c1Busy",  32'(busA.busy),  32'h1);
      stepClock();
      applyStimulus(0, 1'b0, 1'b0, 3'd7, 3'd1, 12'h000);
      checkOutput("t1c2Oe",    32'(busA.oe),      32'h04);
      checkOutput("t1c2Latch", 32'(busA.latch),   32'h20);
      checkOutput("t1c2Cap",   32'(busA.bus_cap), 32'o5252);
      stepClock();
      checkOutput("t1c3Oe",    32'(busA.oe),    32'h04);
      checkOutput("t1c3Latch", 32'(busA.latch), 32'h00);
      checkOutput("t1c3Done",  32'(busA.done),  32'h0);
      stepClock();
      checkOutput("t1c4Oe",    32'(busA.oe),   32'h00);
      checkOutput("t1c4Done",  32'(busA.done), 32'h1);
      checkOutput("t1c4Err",   32'(busA.err),  32'h0);
      checkOutput("t1c4Busy",  32'(busA.busy), 32'h1);
      stepClock();
      checkOutput("t1c5Done",  32'(busA.done),    32'h0);
      checkOutput("t1c5Busy",  32'(busA.busy),    32'h0);
      checkOutput("t1c5Cap",   32'(busA.bus_cap), 32'o5252);

      // Clear-only operation on dst=3.
      $display("[TB] clear dst=3");
      applyStimulus(0, 1'b1, 1'b1, 3'd6, 3'd3, 12'h000);
      stepClock();
      applyStimulus(0, 1'b0, 1'b0, 3'd0, 3'd0, 12'h000);
      checkOutput("t2c1Clear", 32'(busA.clear), 32'h08);
      checkOutput("t2c1Oe",    32'(busA.oe),    32'h00);
      checkOutput("t2c1Done",  32'(busA.done),  32'h0);
      stepClock();
      checkOutput("t2c2Clear", 32'(busA.clear), 32'h00);
      checkOutput("t2c2Done",  32'(busA.done),  32'h1);
      checkOutput("t2c2Err",   32'(busA.err),   32'h0);
      stepClock();
      checkOutput("t2c3Busy",  32'(busA.busy),  32'h0);

      // SETTLE=3, STROBE=2 transfer src=4 -> dst=0 on B.
      $display("[TB] long transfer on B");
      applyStimulus(1, 1'b1, 1'b0, 3'd4, 3'd0, 12'h3C5);
      stepClock();
      applyStimulus(1, 1'b0, 1'b0, 3'd1, 3'd2, 12'h3C5);
      for (int c = 1; c <= 7; c++) begin
         checkOutput($sformatf("t6c%0dOe", c), 32'(busB.oe), (c <= 6) ? 32'h10 : 32'h00);
         checkOutput($sformatf("t6c%0dLatch", c), 32'(busB.latch), (c == 4 || c == 5) ? 32'h01 : 32'h00);
         checkOutput($sformatf("t6c%0dDone", c), 32'(busB.done), (c == 7) ? 32'h1 : 32'h0);
         if (c == 4) begin
            applyStimulus(1, 1'b0, 1'b0, 3'd1, 3'd2, 12'h000);
         end
         if (c < 7) begin
            stepClock();
         end
      end
      checkOutput("t6Cap", 32'(busB.bus_cap), 32'h3C5);
      stepClock();
      checkOutput("t6Busy", 32'(busB.busy), 32'h0);

      // Out-of-range source on B: immediate done+err, no strobes, bus_cap kept.
      $display("[TB] out-of-range requests on B");
      applyStimulus(1, 1'b1, 1'b0, 3'd7, 3'd1, 12'hFFF);
      stepClock();
      applyStimulus(1, 1'b0, 1'b0, 3'd0, 3'd0, 12'hFFF);
      checkOutput("t3Done",  32'(busB.done),    32'h1);
      checkOutput("t3Err",   32'(busB.err),     32'h1);
      checkOutput("t3Oe",    32'(busB.oe),      32'h00);
      checkOutput("t3Latch", 32'(busB.latch),   32'h00);
      checkOutput("t3Clear", 32'(busB.clear),   32'h00);
      checkOutput("t3Cap",   32'(busB.bus_cap), 32'h3C5);
      stepClock();
      checkOutput("t3Busy",  32'(busB.busy), 32'h0);
      checkOutput("t3ErrLo", 32'(busB.err),  32'h0);

      // Out-of-range destination with clr_op.
      applyStimulus(1, 1'b1, 1'b1, 3'd0, 3'd6, 12'h000);
      stepClock();
      applyStimulus(1, 1'b0, 1'b0, 3'd0, 3'd0, 12'h000);
      checkOutput("t3bErr",   32'(busB.err),   32'h1);
      checkOutput("t3bClear", 32'(busB.clear), 32'h00);
      stepClock();

      // Clear with an out-of-range src: src is ignored, STROBE=2 clear.
      applyStimulus(1, 1'b1, 1'b1, 3'd7, 3'd2, 12'h000);
      stepClock();
      applyStimulus(1, 1'b0, 1'b0, 3'd0, 3'd0, 12'h000);
      checkOutput("t3cC1Clear", 32'(busB.clear), 32'h04);
      stepClock();
      checkOutput("t3cC2Clear", 32'(busB.clear), 32'h04);
      checkOutput("t3cC2Done",  32'(busB.done),  32'h0);
      stepClock();
      checkOutput("t3cC3Clear", 32'(busB.clear), 32'h00);
      checkOutput("t3cC3Done",  32'(busB.done),  32'h1);
      checkOutput("t3cC3Err",   32'(busB.err),   32'h0);
      stepClock();

      // Reset while strobing, then a clean transfer.
      $display("[TB] reset during strobe");
      applyStimulus(0, 1'b1, 1'b0, 3'd1, 3'd6, 12'h123);
      stepClock();
      applyStimulus(0, 1'b0, 1'b0, 3'd1, 3'd6, 12'h123);
      stepClock();
      checkOutput("t4StrbLatch", 32'(busA.latch), 32'h40);
      reset_n = 1'b0;
      stepClock();
      checkOutput("t4RstOe",    32'(busA.oe),      32'h00);
      checkOutput("t4RstLatch", 32'(busA.latch),   32'h00);
      checkOutput("t4RstBusy",  32'(busA.busy),    32'h0);
      checkOutput("t4RstCap",   32'(busA.bus_cap), 32'h000);
      checkOutput("t4RstDone",  32'(busA.done),    32'h0);
      reset_n = 1'b1;
      applyStimulus(0, 1'b1, 1'b0, 3'd0, 3'd7, 12'hABC);
      stepClock();
      applyStimulus(0, 1'b0, 1'b0, 3'd0, 3'd0, 12'hABC);
      checkOutput("t4NewOe", 32'(busA.oe), 32'h01);
      stepClock();
      checkOutput("t4NewLatch", 32'(busA.latch), 32'h80);
      stepClock();
      stepClock();
      checkOutput("t4NewDone", 32'(busA.done),    32'h1);
      checkOutput("t4NewCap",  32'(busA.bus_cap), 32'hABC);
      stepClock();

      // req held high: back-to-back transfers every five edges; a src change
      // mid-transfer only affects the next accepted transfer.
      $display("[TB] back-to-back requests");
      applyStimulus(0, 1'b1, 1'b0, 3'd3, 3'd2, 12'h055);
      for (int c = 1; c <= 20; c++) begin
         stepClock();
         ph    = (c - 1) % 5;
         oeExp = (c <= 5) ? 8'h08 : 8'h20;
         checkOutput($sformatf("t5c%0dOe", c), 32'(busA.oe), (ph < 3) ? 32'(oeExp) : 32'h00);
         checkOutput($sformatf("t5c%0dLatch", c), 32'(busA.latch), (ph == 1) ? 32'h04 : 32'h00);
         checkOutput($sformatf("t5c%0dDone", c), 32'(busA.done), (ph == 3) ? 32'h1 : 32'h0);
         if (c == 2) begin
            applyStimulus(0, 1'b1, 1'b0, 3'd5, 3'd2, 12'h055);
         end
      end
      applyStimulus(0, 1'b0, 1'b0, 3'd5, 3'd2, 12'h055);
      stepClock();
      checkOutput("t5EndBusy", 32'(busA.busy), 32'h0);
      checkOutput("t5EndOe",   32'(busA.oe),   32'h00);

      monOn = 1'b0;
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
